// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned N_DATA = 3,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]         in_rd,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [REG_W-1:0]         out_rd,
    output logic [CTRL_W-1:0]        out_ctrl
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int unsigned BUS_W = N_DATA * DATA_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_in_ready;
    logic              r_out_valid;
    logic [BUS_W-1:0]  r_main_data;
    logic [REG_W-1:0]  r_main_rd;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [BUS_W-1:0]  r_skid_data;
    logic [REG_W-1:0]  r_skid_rd;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_accept;
    logic w_retire;
    logic w_load_main;
    logic w_load_skid;
    logic w_move_skid;

    assign w_accept = in_valid & r_in_ready;
    assign w_retire = r_out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_accept && !w_retire)      w_state_nxt = S_TWO;
                else if (w_retire && !w_accept) w_state_nxt = S_EMPTY;
            end
            S_TWO:   if (w_retire) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) w_state_nxt = S_EMPTY;
    end

    // Datapath load controls
    always_comb begin
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_load_main = w_accept;
                S_ONE: begin
                    w_load_main = w_accept & w_retire;
                    w_load_skid = w_accept & ~w_retire;
                end
                S_TWO:   w_move_skid = w_retire;
                default: ;
            endcase
        end
    end

    // Entry storage; main ctrl is zeroed whenever the stage goes empty so bubbles carry no control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_data <= '0;
            r_main_rd   <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt != S_TWO);
            r_out_valid <= (w_state_nxt != S_EMPTY);
            if (w_load_main) begin
                r_main_data <= in_data;
                r_main_rd   <= in_rd;
                r_main_ctrl <= in_ctrl;
            end else if (w_move_skid) begin
                r_main_data <= r_skid_data;
                r_main_rd   <= r_skid_rd;
                r_main_ctrl <= r_skid_ctrl;
            end else if (w_state_nxt == S_EMPTY) begin
                r_main_ctrl <= '0;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_rd   <= in_rd;
                r_skid_ctrl <= in_ctrl;
            end else if (w_move_skid) begin
                r_skid_data <= '0;
                r_skid_rd   <= '0;
                r_skid_ctrl <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign out_rd    = r_main_rd;
    assign out_ctrl  = r_main_ctrl;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of stalled-head cycles; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
